// File: rtl/bootram_port_arbiter.sv
// ----------------------------------------------------------------------------
// bootram_port_arbiter
//
// Shares one read/write port of the 32-bit boot ROM/RAM between the host CPU
// (requester A) and the loader/OSD uploader (requester B). Requests are
// arbitrated round-robin, the RAM port is driven from registers, the one-cycle
// synchronous read latency is absorbed, and each access completes with a
// single-cycle acknowledge. While lock is high, CPU writes are acknowledged but
// never reach the RAM.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_d/a_bytesel   requester A access (held until a_ack)
//   a_q, a_ack                  A read data (held until next A ack), ack pulse
//   b_*                         same as A, for requester B
//   lock                        suppresses A writes while high
//   ram_addr/ram_d/ram_we/ram_bytesel  registered RAM port
//   ram_q                       RAM read data, valid one cycle after ram_addr
//   busy                        high whenever an access is in flight
// ----------------------------------------------------------------------------
module bootram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4,
    localparam int DATA_WIDTH = COL_WIDTH * NB_COL
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_d,
    input  logic [NB_COL-1:0]     a_bytesel,
    output logic [DATA_WIDTH-1:0] a_q,
    output logic                  a_ack,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_d,
    input  logic [NB_COL-1:0]     b_bytesel,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic                  b_ack,

    input  logic                  lock,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_we,
    output logic [NB_COL-1:0]     ram_bytesel,
    input  logic [DATA_WIDTH-1:0] ram_q,

    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } requester_e;

    state_e                  state_q, state_d;
    // The most recent winner doubles as the owner of the access in flight:
    // it is only updated in IDLE, so it is stable through ISSUE and DATA.
    requester_e              last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_d_q, ram_d_d;
    logic                    ram_we_q, ram_we_d;
    logic [NB_COL-1:0]       ram_bytesel_q, ram_bytesel_d;
    logic [DATA_WIDTH-1:0]   a_q_q, a_q_d;
    logic [DATA_WIDTH-1:0]   b_q_q, b_q_d;
    logic                    a_ack_q, a_ack_d;
    logic                    b_ack_q, b_ack_d;
    logic                    busy_q, busy_d;
    logic                    pick_b;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        ram_addr_d    = ram_addr_q;
        ram_d_d       = ram_d_q;
        ram_we_d      = 1'b0;          // write strobe lasts the ISSUE cycle only
        ram_bytesel_d = ram_bytesel_q;
        a_q_d         = a_q_q;
        b_q_d         = b_q_q;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        pick_b        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    // On a tie the requester that did not win last time goes.
                    pick_b = b_req && (!a_req || (last_grant_q == REQ_A));
                    if (pick_b) begin
                        ram_addr_d    = b_addr;
                        ram_d_d       = b_d;
                        ram_bytesel_d = b_bytesel;
                        ram_we_d      = b_we;
                        last_grant_d  = REQ_B;
                    end else begin
                        ram_addr_d    = a_addr;
                        ram_d_d       = a_d;
                        ram_bytesel_d = a_bytesel;
                        // A locked image ignores CPU writes; the access still
                        // runs its course so the CPU sees a normal ack.
                        ram_we_d      = a_we && !lock;
                        last_grant_d  = REQ_A;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (last_grant_q == REQ_A) begin
                    a_q_d   = ram_q;
                    a_ack_d = 1'b1;
                end else begin
                    b_q_d   = ram_q;
                    b_ack_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= REQ_B;
            ram_addr_q    <= '0;
            ram_d_q       <= '0;
            ram_we_q      <= 1'b0;
            ram_bytesel_q <= '0;
            a_q_q         <= '0;
            b_q_q         <= '0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            ram_addr_q    <= ram_addr_d;
            ram_d_q       <= ram_d_d;
            ram_we_q      <= ram_we_d;
            ram_bytesel_q <= ram_bytesel_d;
            a_q_q         <= a_q_d;
            b_q_q         <= b_q_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
            busy_q        <= busy_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_d       = ram_d_q;
    assign ram_we      = ram_we_q;
    assign ram_bytesel = ram_bytesel_q;
    assign a_q         = a_q_q;
    assign b_q         = b_q_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bootram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bootram_port_arbiter
//
// Bench for bootram_port_arbiter. A synchronous read-first RAM sits on the
// RAM port. The reference model treats the arbiter as a serialising port:
// each completed access is applied, in ack order, to a word array, and the
// winner of a contested cycle is the requester that did not win last.
// ----------------------------------------------------------------------------
module tb_bootram_port_arbiter;

    localparam int AW = 14;
    localparam int CW = 8;
    localparam int NC = 4;
    localparam int DW = CW * NC;
    localparam logic WHO_A = 1'b0;
    localparam logic WHO_B = 1'b1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        logic [NC-1:0] be;
    } op_t;

    logic          clk;
    logic          reset;
    logic          a_req, a_we, a_ack;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_d, a_q;
    logic [NC-1:0] a_bytesel;
    logic          b_req, b_we, b_ack;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_d, b_q;
    logic [NC-1:0] b_bytesel;
    logic          lock;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d, ram_q;
    logic          ram_we;
    logic [NC-1:0] ram_bytesel;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [0:15];
    logic          last_winner;
    logic [DW-1:0] exp_a_q, exp_b_q;

    bootram_port_arbiter #(.ADDR_WIDTH(AW), .COL_WIDTH(CW), .NB_COL(NC)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_d(a_d),
        .a_bytesel(a_bytesel), .a_q(a_q), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_d(b_d),
        .b_bytesel(b_bytesel), .b_q(b_q), .b_ack(b_ack),
        .lock(lock),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we),
        .ram_bytesel(ram_bytesel), .ram_q(ram_q),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i < 4) ? '0 : (32'h1000_0000 + DW'(i) * 32'h0101_0101);
    endfunction

    // Synchronous read-first RAM with byte enables
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = (i < 16) ? init_word(i) : '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NC; i++)
                if (ram_we && ram_bytesel[i]) ram_mem[ram_addr][i*CW +: CW] <= ram_d[i*CW +: CW];
            ram_q <= ram_mem[ram_addr];
        end
    end

    always @(negedge clk) if (ram_we) we_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required $finish");
        $fatal(1);
    end

    // ---------------- model and drivers ----------------
    task automatic model_reset();
        last_winner = WHO_B;
        exp_a_q = '0;
        exp_b_q = '0;
    endtask

    task automatic model_access(input logic who, input op_t op, output logic [DW-1:0] q);
        q = ref_mem[op.addr[3:0]];
        if (op.we && !(who == WHO_A && lock))
            for (int i = 0; i < NC; i++)
                if (op.be[i]) ref_mem[op.addr[3:0]][i*CW +: CW] = op.d[i*CW +: CW];
        if (who == WHO_A) exp_a_q = q; else exp_b_q = q;
        last_winner = who;
    endtask

    task automatic drive(input logic who, input op_t op);
        if (who == WHO_A) begin
            a_we = op.we; a_addr = op.addr; a_d = op.d; a_bytesel = op.be;
        end else begin
            b_we = op.we; b_addr = op.addr; b_d = op.d; b_bytesel = op.be;
        end
    endtask

    task automatic new_op(output op_t op);
        op.we   = 1'($urandom_range(0, 1));
        op.addr = AW'($urandom_range(0, 15));
        op.d    = $urandom;
        op.be   = NC'($urandom_range(0, 15));
    endtask

    // Runs one access; lat counts clock edges from the edge before req rises
    // to the edge after which ack is seen (-1 on timeout).
    task automatic do_access(input logic who, input op_t op,
                             output logic [DW-1:0] act_q, output logic [DW-1:0] exp_q,
                             output int lat);
        @(posedge clk); #1;
        drive(who, op);
        if (who == WHO_A) a_req = 1'b1; else b_req = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if ((who == WHO_A) ? a_ack : b_ack) begin lat = n; break; end
        end
        if (who == WHO_A) a_req = 1'b0; else b_req = 1'b0;
        act_q = (who == WHO_A) ? a_q : b_q;
        if (lat > 0) model_access(who, op, exp_q);
        else exp_q = 32'hDEAD_BEEF;
    endtask

    task automatic apply_reset();
        reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Both requesters assert continuously; each gets a fresh random op after
    // its ack. Checks winner order, read data, ack overlap and q holding.
    task automatic run_concurrent(input string tag, input int n_acc, input logic lock_val);
        op_t a_op, b_op;
        int done = 0;
        int cyc  = 0;
        logic who, exp_who;
        logic [DW-1:0] eq;
        lock = lock_val;
        new_op(a_op); new_op(b_op);
        @(posedge clk); #1;
        drive(WHO_A, a_op); drive(WHO_B, b_op);
        a_req = 1'b1; b_req = 1'b1;
        while (done < n_acc && cyc < 20 * n_acc) begin
            @(negedge clk); cyc++;
            n_checks++;
            if (a_ack && b_ack) $display("FAIL %s ack_overlap: got both acks, required at most one", tag);
            else n_pass++;
            if (a_ack || b_ack) begin
                who = a_ack ? WHO_A : WHO_B;
                exp_who = (last_winner == WHO_A) ? WHO_B : WHO_A;
                model_access(who, (who == WHO_A) ? a_op : b_op, eq);
                n_checks++;
                if (who !== exp_who) $display("FAIL %s grant_order[%0d]: got %0s required %0s", tag, done,
                                              who ? "B" : "A", exp_who ? "B" : "A");
                else n_pass++;
                done++;
                if (done < n_acc) begin
                    if (who == WHO_A) begin new_op(a_op); drive(WHO_A, a_op); end
                    else begin new_op(b_op); drive(WHO_B, b_op); end
                end
            end
            n_checks++;
            if (a_q !== exp_a_q || b_q !== exp_b_q)
                $display("FAIL %s q_hold: got a_q=%h b_q=%h required a_q=%h b_q=%h", tag, a_q, b_q, exp_a_q, exp_b_q);
            else n_pass++;
        end
        a_req = 1'b0; b_req = 1'b0;
        n_checks++;
        if (done != n_acc) $display("FAIL %s completion: got %0d accesses required %0d", tag, done, n_acc);
        else n_pass++;
        repeat (3) @(negedge clk);
        lock = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, ram_we, a_ack, b_ack} !== 4'b0)
            $display("FAIL reset_ctrl: got busy/we/a_ack/b_ack=%b required 0000", {busy, ram_we, a_ack, b_ack});
        else n_pass++;
        n_checks++;
        if (ram_addr !== '0 || ram_d !== '0 || ram_bytesel !== '0)
            $display("FAIL reset_port: got addr=%h d=%h be=%h required all 0", ram_addr, ram_d, ram_bytesel);
        else n_pass++;
        n_checks++;
        if (a_q !== '0 || b_q !== '0) $display("FAIL reset_q: got a_q=%h b_q=%h required 0", a_q, b_q);
        else n_pass++;
    endtask

    task automatic test_single_write_read();
        logic [DW-1:0] aq, eq;
        int lat, w0;
        w0 = we_cnt;
        do_access(WHO_A, '{we:1'b1, addr:'0, d:32'hAABBCCDD, be:4'hF}, aq, eq, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL write_latency: got %0d edges required 3", lat); else n_pass++;
        n_checks++;
        if (we_cnt - w0 !== 1) $display("FAIL write_we_cycles: got %0d required 1", we_cnt - w0); else n_pass++;
        w0 = we_cnt;
        do_access(WHO_A, '{we:1'b0, addr:'0, d:'0, be:4'hF}, aq, eq, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL read_latency: got %0d edges required 3", lat); else n_pass++;
        n_checks++;
        if (aq !== 32'hAABBCCDD) $display("FAIL read_back0: got %h required AABBCCDD", aq); else n_pass++;
        n_checks++;
        if (we_cnt !== w0) $display("FAIL read_no_we: got %0d pulses required 0", we_cnt - w0); else n_pass++;
    endtask

    task automatic test_partial_writes();
        logic [DW-1:0] aq, eq;
        int lat;
        do_access(WHO_A, '{we:1'b1, addr:14'd1, d:32'hAABBCCDD, be:4'b0011}, aq, eq, lat);
        do_access(WHO_A, '{we:1'b1, addr:14'd2, d:32'hAABBCCDD, be:4'b1100}, aq, eq, lat);
        do_access(WHO_A, '{we:1'b0, addr:14'd1, d:'0, be:4'hF}, aq, eq, lat);
        n_checks++;
        if (aq !== 32'h0000CCDD) $display("FAIL partial_lo: got %h required 0000CCDD", aq); else n_pass++;
        do_access(WHO_A, '{we:1'b0, addr:14'd2, d:'0, be:4'hF}, aq, eq, lat);
        n_checks++;
        if (aq !== 32'hAABB0000) $display("FAIL partial_hi: got %h required AABB0000", aq); else n_pass++;
        // Zero byte enables: strobe still pulses, nothing changes.
        do_access(WHO_B, '{we:1'b1, addr:14'd2, d:32'h11111111, be:4'b0000}, aq, eq, lat);
        do_access(WHO_B, '{we:1'b0, addr:14'd2, d:'0, be:4'hF}, aq, eq, lat);
        n_checks++;
        if (aq !== eq) $display("FAIL be_zero: got %h required %h", aq, eq); else n_pass++;
    endtask

    task automatic test_lock();
        logic [DW-1:0] q, eq;
        int lat, w0;
        lock = 1'b1;
        w0 = we_cnt;
        do_access(WHO_A, '{we:1'b1, addr:14'd3, d:32'h12345678, be:4'hF}, q, eq, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL lock_ack: got latency %0d required 3", lat); else n_pass++;
        n_checks++;
        if (we_cnt !== w0) $display("FAIL lock_we: got %0d pulses required 0", we_cnt - w0); else n_pass++;
        do_access(WHO_A, '{we:1'b0, addr:14'd3, d:'0, be:4'hF}, q, eq, lat);
        n_checks++;
        if (q !== 32'h0) $display("FAIL lock_unchanged: got %h required 00000000", q); else n_pass++;
        do_access(WHO_B, '{we:1'b1, addr:14'd3, d:32'h12345678, be:4'hF}, q, eq, lat);
        do_access(WHO_B, '{we:1'b0, addr:14'd3, d:'0, be:4'hF}, q, eq, lat);
        n_checks++;
        if (q !== 32'h12345678) $display("FAIL lock_b_write: got %h required 12345678", q); else n_pass++;
        n_checks++;
        if (a_q !== exp_a_q) $display("FAIL lock_a_hold: got %h required %h", a_q, exp_a_q); else n_pass++;
        lock = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int acks = 0;
        @(posedge clk); #1;
        drive(WHO_A, '{we:1'b0, addr:14'd5, d:'0, be:4'hF});
        a_req = 1'b1;
        @(posedge clk); #1;                  // granted; now in ISSUE
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_busy_issue: got %b required 1", busy); else n_pass++;
        reset = 1'b1; a_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0)
            $display("FAIL mid_reset_state: got busy=%b ram_we=%b required 0 0", busy, ram_we);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (a_ack) acks++;
            @(negedge clk);
        end
        n_checks++;
        if (acks !== 0) $display("FAIL mid_no_ack: got %0d acks required 0", acks); else n_pass++;
        n_checks++;
        if (a_q !== '0) $display("FAIL mid_a_q: got %h required 00000000", a_q); else n_pass++;
        run_concurrent("post_reset_tie", 2, 1'b0);
    endtask

    task automatic test_req_glitch();
        int lat = -1;
        int w0, extra_acks, busy_cycles;
        logic [DW-1:0] eq;
        op_t op;
        op = '{we:1'b1, addr:14'd7, d:$urandom, be:4'hF};
        w0 = we_cnt;
        @(posedge clk); #1;
        drive(WHO_A, op);
        a_req = 1'b1;
        @(posedge clk); #1 a_req = 1'b0;     // seen in exactly one IDLE cycle
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (a_ack) begin lat = n; break; end
        end
        n_checks++;
        if (lat !== 3) $display("FAIL glitch_latency: got %0d edges required 3", lat); else n_pass++;
        model_access(WHO_A, op, eq);
        n_checks++;
        if (a_q !== eq) $display("FAIL glitch_q: got %h required %h", a_q, eq); else n_pass++;
        extra_acks = 0; busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) extra_acks++;
            if (busy) busy_cycles++;
        end
        n_checks++;
        if (extra_acks !== 0 || busy_cycles !== 0 || we_cnt - w0 !== 1)
            $display("FAIL glitch_single: got acks=%0d busy=%0d we=%0d required 0 0 1",
                     extra_acks, busy_cycles, we_cnt - w0);
        else n_pass++;
        do_access(WHO_B, '{we:1'b0, addr:14'd7, d:'0, be:4'hF}, eq, eq, lat);
        n_checks++;
        if (b_q !== op.d) $display("FAIL glitch_readback: got %h required %h", b_q, op.d); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; lock = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_d = '0; a_bytesel = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_d = '0; b_bytesel = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        model_reset();

        test_reset();
        test_single_write_read();
        test_partial_writes();
        test_lock();
        run_concurrent("simultaneous", 6, 1'b0);
        run_concurrent("random_locked", 10, 1'b1);
        run_concurrent("random_open", 12, 1'b0);
        test_reset_mid_access();
        test_req_glitch();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
